hps_fifo_drain: RTL and testbench

//  FPGA-side reader for the HPS-to-FPGA Avalon FIFO (out + out_csr slaves of Computer_System).

---
 rtl/hps_fifo_pkg.sv | 21 ++
 rtl/hps_fifo_drain_if.sv | 31 +++
 rtl/stream_buf.sv | 64 ++++++
 rtl/hps_fifo_drain.sv | 143 ++++++++++++++
 tb/tb_hps_fifo_drain.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hps_fifo_pkg.sv
// Shared constants and types for the HPS-to-FPGA FIFO drain block.
//   WORD_W      : data word width of the FIFO slaves and the output stream
//   FILL_LEVEL  : out_csr register address of the fill level
//   I_STATUS    : out_csr register address of the interrupt status
//   state_e     : drain FSM states
package hps_fifo_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] FILL_LEVEL = 3'd0;
    localparam logic [2:0] I_STATUS   = 3'd1;

    typedef enum logic [2:0] {
        StIdle,
        StPoll,
        StWaitCsr,
        StDrain,
        StGap
    } state_e;

endpackage

// File: rtl/hps_fifo_drain_if.sv
// Bus bundle between the drain block and the Computer_System FIFO slaves plus the
// outgoing word stream.
//   csr_*     : out_csr slave (address, read, write, writedata, readdata)
//   fifo_*    : out slave (read strobe, readdata)
//   m_*       : 32-bit valid/ready output stream
// Modport master is the drain block; modport slave is the FIFO side and stream sink.
interface hps_fifo_drain_if;
    import hps_fifo_pkg::*;

    logic [2:0]        csr_address;
    logic              csr_read;
    logic              csr_write;
    logic [WORD_W-1:0] csr_writedata;
    logic [WORD_W-1:0] csr_readdata;
    logic              fifo_read;
    logic [WORD_W-1:0] fifo_readdata;
    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output csr_address, csr_read, csr_write, csr_writedata, fifo_read, m_data, m_valid,
        input  csr_readdata, fifo_readdata, m_ready
    );

    modport slave (
        input  csr_address, csr_read, csr_write, csr_writedata, fifo_read, m_data, m_valid,
        output csr_readdata, fifo_readdata, m_ready
    );

endinterface

// File: rtl/stream_buf.sv
// Synchronous first-word-fall-through FIFO.
//   clk, reset_n : clock, asynchronous active-low reset
//   push         : write push_data this cycle (ignored when full unless popping too)
//   push_data    : word to write
//   pop          : consume the head word (ignored when empty)
//   pop_data     : head word, 0 when empty
//   empty        : no words stored
//   occupancy    : number of stored words, 0..DEPTH
module stream_buf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Gate the head so outputs are 0 while empty, including straight out of reset.
    assign pop_data  = empty ? '0 : mem[rd_ptr];
    assign occupancy = count;

endmodule

// File: rtl/hps_fifo_drain.sv
// FPGA-side reader for the HPS-to-FPGA Avalon FIFO. Polls the CSR fill level, pops that
// many words from the out slave into a local buffer and presents them as a valid/ready
// stream. Pulses rx_irq when a poll finds the FIFO empty after words were drained.
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : 1 runs the poll/drain loop; 0 lets in-flight reads land, then idles
//   bus          : master side of hps_fifo_drain_if (CSR slave, out slave, stream)
//   rx_irq       : one-cycle interrupt pulse toward the HPS
module hps_fifo_drain
    import hps_fifo_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned FILL_W    = 8,
    parameter int unsigned POLL_GAP  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    hps_fifo_drain_if.master        bus,
    output logic                    rx_irq
);

    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned CRED_W = CNT_W + 1;
    localparam int unsigned GAP_W  = $clog2(POLL_GAP) + 1;

    state_e            state;
    logic [FILL_W-1:0] remaining;
    logic [FILL_W-1:0] fill;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  occupancy;
    logic [CRED_W-1:0] credit;
    logic [RD_LAT-1:0] vld_sr;
    logic [GAP_W-1:0]  gap_cnt;
    logic              drained_flag;
    logic              rx_irq_q;
    logic              issue;
    logic              retire;
    logic              buf_empty;
    logic [WORD_W-1:0] head;
    logic              unused_csr_hi;

    assign fill          = bus.csr_readdata[FILL_W-1:0];
    assign unused_csr_hi = ^bus.csr_readdata[WORD_W-1:FILL_W];

    // Buffer slots not yet claimed by stored words or reads still in the pipe.
    assign credit = CRED_W'(BUF_DEPTH) - CRED_W'(occupancy) - CRED_W'(inflight);
    assign issue  = (state == StDrain) && enable && (remaining != '0) && (credit != '0);
    assign retire = vld_sr[RD_LAT-1];

    // Tracks each issued read until its readdata is valid on the out slave.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= StIdle;
            remaining    <= '0;
            inflight     <= '0;
            gap_cnt      <= '0;
            drained_flag <= 1'b0;
            rx_irq_q     <= 1'b0;
        end else begin
            rx_irq_q <= 1'b0;
            inflight <= inflight + CNT_W'(issue) - CNT_W'(retire);
            if (issue) begin
                remaining    <= remaining - FILL_W'(1);
                drained_flag <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (enable) begin
                        state <= StPoll;
                    end
                end
                StPoll: begin
                    state <= StWaitCsr;
                end
                StWaitCsr: begin
                    remaining <= fill;
                    if (fill != '0) begin
                        state <= StDrain;
                    end else begin
                        state        <= StGap;
                        gap_cnt      <= '0;
                        rx_irq_q     <= drained_flag;
                        drained_flag <= 1'b0;
                    end
                end
                StDrain: begin
                    // enable=0 only stops new reads; leave once the pipe is empty.
                    if ((inflight == '0) && ((remaining == '0) || !enable)) begin
                        state <= enable ? StPoll : StIdle;
                    end
                end
                StGap: begin
                    if (!enable) begin
                        state <= StIdle;
                    end else if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
                        state <= StPoll;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    stream_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (WORD_W)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (retire),
        .push_data (bus.fifo_readdata),
        .pop       (bus.m_ready),
        .pop_data  (head),
        .empty     (buf_empty),
        .occupancy (occupancy)
    );

    assign bus.csr_address   = FILL_LEVEL;
    assign bus.csr_read      = (state == StPoll);
    assign bus.csr_write     = 1'b0;
    assign bus.csr_writedata = '0;
    assign bus.fifo_read     = issue;
    assign bus.m_data        = head;
    assign bus.m_valid       = !buf_empty;
    assign rx_irq            = rx_irq_q;

endmodule

// File: tb/tb_hps_fifo_drain.sv
// Directed bench for hps_fifo_drain with a behavioural model of the HPS-to-FPGA FIFO
// (CSR fill level + out slave with RD_LAT=2) and a stream sink scoreboard.
module tb_hps_fifo_drain;
    import hps_fifo_pkg::*;

    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned FILL_W    = 8;
    localparam int unsigned POLL_GAP  = 16;

    logic clk;
    logic reset_n;
    logic enable;
    logic rx_irq;

    hps_fifo_drain_if bus ();

    hps_fifo_drain #(
        .BUF_DEPTH (BUF_DEPTH),
        .RD_LAT    (RD_LAT),
        .FILL_W    (FILL_W),
        .POLL_GAP  (POLL_GAP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .bus     (bus),
        .rx_irq  (rx_irq)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] hps_q[$];
    logic [31:0] got[$];
    int          poll_times[$];
    int          cyc = 0;
    int          csr_cnt, fr_cnt, irq_cnt, underflow, max_occ;
    logic [31:0] stage1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // HPS FIFO model: fill level one cycle after csr_read, readdata RD_LAT=2 after read.
    always @(posedge clk) begin
        if (bus.csr_read) bus.csr_readdata <= 32'(hps_q.size());
        if (bus.fifo_read) begin
            if (hps_q.size() == 0) begin
                underflow = underflow + 1;
                stage1 <= 32'hDEAD_0000;
            end else begin
                stage1 <= hps_q.pop_front();
            end
        end
        bus.fifo_readdata <= stage1;
    end

    // Monitors sample mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.csr_read) begin
            csr_cnt = csr_cnt + 1;
            poll_times.push_back(cyc);
        end
        if (bus.fifo_read) fr_cnt = fr_cnt + 1;
        if (rx_irq) irq_cnt = irq_cnt + 1;
        if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
        if (int'(dut.occupancy) > max_occ) max_occ = int'(dut.occupancy);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_counts();
        csr_cnt = 0; fr_cnt = 0; irq_cnt = 0; underflow = 0; max_occ = 0;
        got.delete();
        poll_times.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; bus.m_ready = 1'b0;
        stage1 = '0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.csr_read, bus.csr_write, bus.fifo_read, bus.m_valid, rx_irq} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {bus.csr_read, bus.csr_write, bus.fifo_read, bus.m_valid, rx_irq});
        end
        vectors++;
        if (bus.csr_address !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_csr_address: got %0d expected 0", bus.csr_address);
        end
        vectors++;
        if (bus.csr_writedata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_csr_writedata: got %h expected 0", bus.csr_writedata);
        end
        vectors++;
        if (bus.m_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_m_data: got %h expected 0", bus.m_data);
        end
    endtask

    task automatic test_poll_idle();
        enable = 1'b1; bus.m_ready = 1'b1;
        clear_counts();
        reset_n = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        vectors++;
        if (poll_times.size() < 4) begin
            miscompares++;
            $display("FAIL poll_count: got %0d expected >=4", poll_times.size());
        end
        for (int i = 1; i < poll_times.size(); i++) begin
            vectors++;
            if (poll_times[i] - poll_times[i-1] != POLL_GAP + 2) begin
                miscompares++;
                $display("FAIL poll_period[%0d]: got %0d expected %0d", i,
                         poll_times[i] - poll_times[i-1], POLL_GAP + 2);
            end
        end
        vectors++;
        if (fr_cnt != 0) begin
            miscompares++;
            $display("FAIL idle_fifo_read: got %0d reads expected 0", fr_cnt);
        end
        vectors++;
        if (irq_cnt != 0) begin
            miscompares++;
            $display("FAIL idle_irq: got %0d pulses expected 0", irq_cnt);
        end
    endtask

    task automatic test_drain3();
        logic [31:0] exp [3];
        exp[0] = 32'hAAAA_000A; exp[1] = 32'hBBBB_000B; exp[2] = 32'hCCCC_000C;
        clear_counts();
        for (int i = 0; i < 3; i++) hps_q.push_back(exp[i]);
        for (int i = 0; i < 200 && got.size() < 3; i++) @(posedge clk);
        repeat (60) @(posedge clk);
        #1;
        vectors++;
        if (got.size() != 3) begin
            miscompares++;
            $display("FAIL drain3_count: got %0d words expected 3", got.size());
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL drain3_word[%0d]: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 32'hX, exp[i]);
            end
        end
        vectors++;
        if (fr_cnt != 3) begin
            miscompares++;
            $display("FAIL drain3_reads: got %0d expected 3", fr_cnt);
        end
        vectors++;
        if (irq_cnt != 1) begin
            miscompares++;
            $display("FAIL drain3_irq: got %0d pulses expected 1", irq_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [10];
        bus.m_ready = 1'b0;
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            exp[i] = 32'h3000_0000 + 32'(i);
            hps_q.push_back(exp[i]);
        end
        repeat (60) @(posedge clk);
        #1;
        vectors++;
        if (fr_cnt != 4 || bus.fifo_read !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_reads: got %0d reads (now %b) expected 4 (now 0)",
                     fr_cnt, bus.fifo_read);
        end
        vectors++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== exp[0]) begin
            miscompares++;
            $display("FAIL bp_head: got valid=%b data=%h expected valid=1 data=%h",
                     bus.m_valid, bus.m_data, exp[0]);
        end
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (bus.m_data !== exp[0]) begin
            miscompares++;
            $display("FAIL bp_head_stable: got %h expected %h", bus.m_data, exp[0]);
        end
        bus.m_ready = 1'b1;
        for (int i = 0; i < 300 && got.size() < 10; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (got.size() != 10 || fr_cnt != 10) begin
            miscompares++;
            $display("FAIL bp_count: got %0d words %0d reads expected 10 10", got.size(), fr_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL bp_word[%0d]: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 32'hX, exp[i]);
            end
        end
        vectors++;
        if (underflow != 0) begin
            miscompares++;
            $display("FAIL bp_underflow: got %0d empty pops expected 0", underflow);
        end
    endtask

    task automatic test_toggle();
        logic [31:0] exp [8];
        bus.m_ready = 1'b0;
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            exp[i] = 32'h4400_0000 ^ (32'(i) * 32'h0101_0101);
            hps_q.push_back(exp[i]);
        end
        for (int i = 0; i < 400 && got.size() < 8; i++) begin
            @(posedge clk);
            #1 bus.m_ready = ~bus.m_ready;
        end
        bus.m_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (got.size() != 8 || fr_cnt != 8) begin
            miscompares++;
            $display("FAIL tog_count: got %0d words %0d reads expected 8 8", got.size(), fr_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL tog_word[%0d]: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 32'hX, exp[i]);
            end
        end
        vectors++;
        if (max_occ > int'(BUF_DEPTH) || underflow != 0) begin
            miscompares++;
            $display("FAIL tog_occupancy: got max %0d underflow %0d expected <=%0d 0",
                     max_occ, underflow, BUF_DEPTH);
        end
    endtask

    task automatic test_enable_drop();
        logic [31:0] exp [6];
        int n = 0;
        int csr_snap;
        bus.m_ready = 1'b1;
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            exp[i] = 32'h5500_0050 + 32'(i);
            hps_q.push_back(exp[i]);
        end
        for (int i = 0; i < 200 && n < 2; i++) begin
            @(negedge clk);
            if (bus.fifo_read) n++;
        end
        vectors++;
        if (n != 2) begin
            miscompares++;
            $display("FAIL en_wait_reads: got %0d reads expected 2", n);
        end
        @(posedge clk);
        #1 enable = 1'b0;
        csr_snap = csr_cnt;
        repeat (40) @(posedge clk);
        #1;
        vectors++;
        if (got.size() != 2 || fr_cnt != 2) begin
            miscompares++;
            $display("FAIL en_count: got %0d words %0d reads expected 2 2", got.size(), fr_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL en_word[%0d]: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 32'hX, exp[i]);
            end
        end
        vectors++;
        if (csr_cnt - csr_snap != 0) begin
            miscompares++;
            $display("FAIL en_no_poll: got %0d polls expected 0", csr_cnt - csr_snap);
        end
        vectors++;
        if (dut.state !== StIdle || bus.m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL en_idle: got state=%0d valid=%b expected state=%0d valid=0",
                     dut.state, bus.m_valid, StIdle);
        end
        vectors++;
        if (hps_q.size() != 4) begin
            miscompares++;
            $display("FAIL en_left: got %0d words left expected 4", hps_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp [6];
        bus.m_ready = 1'b0;
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            exp[i] = 32'h6600_0060 + 32'(i);
            hps_q.push_back(exp[i]);
        end
        enable = 1'b1;
        for (int i = 0; i < 200 && fr_cnt < 4; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (fr_cnt != 4 || dut.state !== StDrain) begin
            miscompares++;
            $display("FAIL rst_pre: got %0d reads state=%0d expected 4 state=%0d",
                     fr_cnt, dut.state, StDrain);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.csr_read, bus.fifo_read, bus.m_valid, rx_irq} !== 4'b0 ||
            bus.m_data !== 32'd0 || dut.state !== StIdle) begin
            miscompares++;
            $display("FAIL rst_async: got strobes=%b data=%h state=%0d expected 0000 0 %0d",
                     {bus.csr_read, bus.fifo_read, bus.m_valid, rx_irq}, bus.m_data,
                     dut.state, StIdle);
        end
        bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_counts();
        reset_n = 1'b1;
        for (int i = 0; i < 20 && csr_cnt == 0 && fr_cnt == 0; i++) @(posedge clk);
        #1;
        vectors++;
        if (csr_cnt != 1 || fr_cnt != 0) begin
            miscompares++;
            $display("FAIL rst_restart: got %0d polls %0d reads expected 1 0", csr_cnt, fr_cnt);
        end
        for (int i = 0; i < 200 && got.size() < 6; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (got.size() != 6 || hps_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_count: got %0d words %0d left expected 6 0",
                     got.size(), hps_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL rst_word[%0d]: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 32'hX, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_poll_idle();
        test_drain3();
        test_backpressure();
        test_toggle();
        test_enable_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
